ifetch_queue: RTL

Instruction fetch queue sitting directly downstream of the PC register. It turns the current `pc` into in-order instruction-memory requests, tells the next-PC logic when to advance, and buffers returned instructions (tagged with their PC) in a DEPTH-entry queue. Decode drains the queue over a valid/ready handshake. A `flush` discards all queued and in-flight fetches on a redirect.

---
 rtl/ifetch_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches for the current pc,
// tags returned instructions with their pc and hands them to decode.
// A flush discards queued entries and arranges for in-flight responses
// to be dropped as they return.
module ifetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_advance,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Queue pointers and occupancy counters
  logic [AW-1:0]    alloc_ptr_reg;
  logic [AW-1:0]    fill_ptr_reg;
  logic [AW-1:0]    head_ptr_reg;
  logic [CW-1:0]    alloc_cnt_reg;
  logic [CW-1:0]    drop_cnt_reg;

  // Entry storage
  logic [WIDTH-1:0] entry_pc_reg     [DEPTH];
  logic [WIDTH-1:0] entry_instr_reg  [DEPTH];
  logic             entry_filled_reg [DEPTH];

  logic             credit_ok;
  logic             accept;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic [CW-1:0]    filled_cnt;
  logic [CW-1:0]    unfilled_cnt;
  logic [CW-1:0]    flush_sum;
  logic [CW-1:0]    flush_drop;

  // Request side: credits come from registered counts only, so a pop
  // this cycle frees a slot for issue only on the next cycle.
  always_comb begin
    credit_ok      = ({1'b0, alloc_cnt_reg} + {1'b0, drop_cnt_reg}) < DEPTH_C;
    imem_req_valid = rst && !flush && credit_ok;
    accept         = imem_req_valid && imem_req_ready;
    pc_advance     = accept;
    imem_req_addr  = pc;
  end

  // Output side: head entry is presented once its response is registered
  always_comb begin
    out_valid = rst && !flush && (alloc_cnt_reg != '0) && entry_filled_reg[head_ptr_reg];
    pop       = out_valid && out_ready;
    out_pc    = entry_pc_reg[head_ptr_reg];
    out_instr = entry_instr_reg[head_ptr_reg];
  end

  // Count allocated entries still waiting for their response; filled bits
  // are only ever set on allocated entries, so a popcount is exact even
  // when the pointers alias on a full queue.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(entry_filled_reg[i]);
    end
    unfilled_cnt = alloc_cnt_reg - filled_cnt;
  end

  // Response routing and the drop count carried across a flush
  always_comb begin
    rsp_drop  = imem_rsp_valid && (drop_cnt_reg != '0);
    rsp_fill  = imem_rsp_valid && !rsp_drop && (unfilled_cnt != '0) && !flush;
    flush_sum = drop_cnt_reg + unfilled_cnt;
    if (imem_rsp_valid && (flush_sum != '0)) begin
      flush_drop = flush_sum - CW'(1);
    end else begin
      flush_drop = flush_sum;
    end
  end

  // Pointer and counter update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      alloc_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else if (flush) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      alloc_cnt_reg <= '0;
      drop_cnt_reg  <= flush_drop;
    end else begin
      if (accept) alloc_ptr_reg <= alloc_ptr_reg + AW'(1);
      if (rsp_fill) fill_ptr_reg <= fill_ptr_reg + AW'(1);
      if (pop) head_ptr_reg <= head_ptr_reg + AW'(1);
      alloc_cnt_reg <= alloc_cnt_reg + CW'(accept) - CW'(pop);
      if (rsp_drop) drop_cnt_reg <= drop_cnt_reg - CW'(1);
    end
  end

  // Per-entry storage; accept, fill and pop always target distinct slots
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Entry gi: capture pc on allocate, instruction on fill, clear on pop
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_pc_reg[gi]     <= '0;
          entry_instr_reg[gi]  <= '0;
          entry_filled_reg[gi] <= 1'b0;
        end else if (flush) begin
          entry_filled_reg[gi] <= 1'b0;
        end else begin
          if (accept && (alloc_ptr_reg == AW'(gi))) begin
            entry_pc_reg[gi]     <= pc;
            entry_filled_reg[gi] <= 1'b0;
          end
          if (rsp_fill && (fill_ptr_reg == AW'(gi))) begin
            entry_instr_reg[gi]  <= imem_rsp_data;
            entry_filled_reg[gi] <= 1'b1;
          end
          if (pop && (head_ptr_reg == AW'(gi))) begin
            entry_filled_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule
